run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter DIV, default 50000000, number of Clock cycles between execution ticks in RUN mode (legal range 2..2^26-1).
REQ-002 Parameter DEB, default 500000, number of consecutive Clock cycles Step must be stable before a level change is accepted (legal range 2..2^20-1).
REQ-003 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  level: 1 = free-run the processor, 0 = stop.
REQ-006 Step  input  1  raw active-low pushbutton, unsynchronised: each press requests one instruction step.
REQ-007 Halt  input  1  halt status from the control unit, sampled synchronously.
REQ-008 PC  input  5  current program counter from the datapath.
REQ-009 BpAddr  input  5  breakpoint address.
REQ-010 BpValid  input  1  breakpoint armed.
REQ-011 CpuEn  output  1  one-Clock-cycle enable pulse that advances the control unit and datapath by one state.
REQ-012 Running  output  1  high while in RUN.
REQ-013 Halted  output  1  high while in HALTED.
REQ-014 BpHit  output  1  sticky: set when a breakpoint stops execution.
REQ-015 CycleCount  output  16  number of CpuEn pulses issued since reset.

Function
REQ-016 Step shall pass through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEB consecutive identical samples; a press is the accepted 1->0 transition, producing exactly one internal press pulse.
REQ-017 FSM states: IDLE, RUN, STEP, HALTED; reset state IDLE.
REQ-018 IDLE: CpuEn=0; Halt=1 -> HALTED; else Run=1 -> RUN; else press -> STEP.
REQ-019 On entry to RUN the prescaler shall clear to 0; it increments each cycle and, on reaching DIV-1, wraps to 0 and asserts CpuEn for that one cycle, so the first pulse occurs exactly DIV cycles after entry.
REQ-020 RUN: Halt=1 -> HALTED (priority over all); else Run=0 -> IDLE; Step presses are ignored.
REQ-021 STEP: CpuEn=1 for exactly the one cycle spent in STEP, then -> IDLE; if Halt=1 on entry, CpuEn=0 and -> HALTED.
REQ-022 HALTED: CpuEn=0; Run and Step ignored; exited only by Reset.
REQ-023 CpuEn shall be a registered output and never high for two consecutive cycles.
REQ-024 CycleCount shall increment by 1 on every CpuEn pulse and saturate at 0xFFFF (no wrap).
REQ-025 Running and Halted shall be registered and decoded from the current state.

Reset
REQ-026 Reset low shall immediately force: state IDLE, CpuEn=0, Running=0, Halted=0, BpHit=0, CycleCount=0, prescaler=0, synchroniser and debouncer to released (1) with counter 0.
REQ-027 Reset asserted mid-RUN or mid-STEP shall cancel any pending pulse; no CpuEn shall appear in the first cycle after release.

Configuration
REQ-028 Macro BREAKPOINT_EN: when defined, in RUN at a tick where BpValid=1 and PC==BpAddr, the CpuEn pulse shall be suppressed, state -> IDLE, BpHit set (cleared only by Reset); Halt=1 in the same cycle takes priority (-> HALTED, BpHit unchanged).
REQ-029 When BREAKPOINT_EN is undefined, PC, BpAddr, BpValid shall be ignored and BpHit tied to 0; ports remain present.

Verification (DIV=4, DEB=3)
REQ-030 Reset released, Run=1 held 20 cycles -> CpuEn pulses at cycles 4,8,12,16,20 after RUN entry; CycleCount=5; Running=1.
REQ-031 Run=0, Step low for 2 cycles then high -> no CpuEn; Step low 10 cycles -> exactly one CpuEn pulse, CycleCount=1.
REQ-032 Run=1, Halt and Run=0 asserted in same cycle -> Halted=1, Running=0, no further CpuEn despite Run toggles and Step presses.
REQ-033 BREAKPOINT_EN defined, BpValid=1, BpAddr=5, PC=5 at tick -> no CpuEn, Running=0, BpHit=1; undefined -> pulse issued, BpHit=0.
REQ-034 Force CycleCount to 0xFFFE, issue 3 pulses -> CycleCount=0xFFFF; Reset low mid-RUN one cycle before tick -> CpuEn stays 0, all outputs 0.

Source files
------------

// File: rtl/run_controller.sv
// run_controller: run/step/halt sequencer that issues single-cycle CpuEn pulses.
// Optional macro BREAKPOINT_EN stops free-run when PC matches an armed breakpoint.
module run_controller #(
  parameter int DIV = 50000000,
  parameter int DEB = 500000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Step,
  input  logic        Halt,
  input  logic [4:0]  PC,
  input  logic [4:0]  BpAddr,
  input  logic        BpValid,
  output logic        CpuEn,
  output logic        Running,
  output logic        Halted,
  output logic        BpHit,
  output logic [15:0] CycleCount
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] STEP   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam logic [25:0] DIV_LAST = 26'(DIV - 1);
  localparam logic [19:0] DEB_LAST = 20'(DEB - 1);

  logic        step_s1, step_s2;
  logic        deb_level;
  logic [19:0] deb_cnt;
  logic        press;
  logic [1:0]  state, state_d;
  logic [25:0] presc, presc_d;
  logic        tick, en_d, bp_set, bp_match;
  logic [15:0] cycle_cnt;

  // Stage: two-flop synchroniser, idles released (high)
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      step_s1 <= 1'b1;
      step_s2 <= 1'b1;
    end else begin
      step_s1 <= Step;
      step_s2 <= step_s1;
    end
  end

  // Stage: debouncer; press fires on the cycle a low level is accepted
  assign press = deb_level && !step_s2 && (deb_cnt == DEB_LAST);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (step_s2 == deb_level) begin
      deb_cnt   <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_level <= step_s2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt   <= deb_cnt + 20'd1;
    end
  end

`ifdef BREAKPOINT_EN
  assign bp_match = BpValid && (PC == BpAddr);
`else
  assign bp_match = 1'b0;
`endif

  assign tick = (presc == DIV_LAST);

  // Stage: next-state decode; the prescaler only advances while staying in RUN
  always_comb begin
    state_d = state;
    presc_d = '0;
    en_d    = 1'b0;
    bp_set  = 1'b0;
    case (state)
      IDLE: begin
        if (Halt) begin
          state_d = HALTED;
        end else if (Run) begin
          state_d = RUN;
        end else if (press) begin
          state_d = STEP;
          en_d    = 1'b1;
        end
      end
      RUN: begin
        if (Halt) begin
          state_d = HALTED;
        end else if (!Run) begin
          state_d = IDLE;
        end else if (tick && bp_match) begin
          state_d = IDLE;
          bp_set  = 1'b1;
        end else begin
          presc_d = tick ? '0 : presc + 26'd1;
          en_d    = tick;
        end
      end
      STEP:    state_d = Halt ? HALTED : IDLE;
      default: state_d = HALTED;
    endcase
  end

  // Stage: state and registered outputs, aligned with the state they decode
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      presc   <= '0;
      CpuEn   <= 1'b0;
      Running <= 1'b0;
      Halted  <= 1'b0;
    end else begin
      state   <= state_d;
      presc   <= presc_d;
      CpuEn   <= en_d;
      Running <= (state_d == RUN);
      Halted  <= (state_d == HALTED);
    end
  end

  // Counts alongside the enable register so CycleCount already includes a visible pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cycle_cnt <= '0;
    end else if (en_d && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  assign CycleCount = cycle_cnt;

`ifdef BREAKPOINT_EN
  logic bp_hit;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bp_hit <= 1'b0;
    end else if (bp_set) begin
      bp_hit <= 1'b1;
    end
  end

  assign BpHit = bp_hit;
`else
  logic unused_bp;
  assign unused_bp = ^{PC, BpAddr, BpValid, bp_set};
  assign BpHit     = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller (DIV=4, DEB=3); expected pulses queued by stimulus.
module tb_run_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Run = 1'b0;
  logic        Step = 1'b1;
  logic        Halt = 1'b0;
  logic [4:0]  PC = '0;
  logic [4:0]  BpAddr = '0;
  logic        BpValid = 1'b0;
  logic        CpuEn, Running, Halted, BpHit;
  logic [15:0] CycleCount;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c;
  logic prev_en = 1'b0;

  typedef struct {
    int          at;
    logic [15:0] cnt;
  } exp_t;

  exp_t expq[$];

  run_controller #(.DIV(4), .DEB(3)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Run        (Run),
    .Step       (Step),
    .Halt       (Halt),
    .PC         (PC),
    .BpAddr     (BpAddr),
    .BpValid    (BpValid),
    .CpuEn      (CpuEn),
    .Running    (Running),
    .Halted     (Halted),
    .BpHit      (BpHit),
    .CycleCount (CycleCount)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [15:0] cnt);
    exp_t e;
    e.at  = at;
    e.cnt = cnt;
    expq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cpuen"},   {31'd0, CpuEn},   32'd0);
    check({tag, "_running"}, {31'd0, Running}, 32'd0);
    check({tag, "_halted"},  {31'd0, Halted},  32'd0);
    check({tag, "_bphit"},   {31'd0, BpHit},   32'd0);
    check({tag, "_count"},   {16'd0, CycleCount}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0; Run = 1'b0; Step = 1'b1; Halt = 1'b0;
    BpValid = 1'b0; BpAddr = '0; PC = '0;
    tick(2);
    check_zero(tag);
    Reset = 1'b1;
    tick(1);
  endtask

  // Monitor: every CpuEn pulse must match the head of the expectation queue
  always @(negedge Clock) begin
    if (CpuEn === 1'b1) begin
      check("no_back_to_back", {31'd0, prev_en}, 32'd0);
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cpuen: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("pulse_cycle", cyc, expq[0].at);
        check("pulse_count", {16'd0, CycleCount}, {16'd0, expq[0].cnt});
        void'(expq.pop_front());
      end
    end
    prev_en <= CpuEn;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check_zero("reset_initial");
    Reset = 1'b1;
    tick(1);

    // Free run: pulses 4,8,12,16,20 cycles after RUN entry
    do_reset("reset_t1");
    c = cyc;
    Run = 1'b1;
    for (int k = 1; k <= 5; k++) push(c + 1 + 4 * k, 16'(k));
    tick(21);
    check("t1_running", {31'd0, Running}, 32'd1);
    check("t1_count", {16'd0, CycleCount}, 32'd5);
    Run = 1'b0;
    tick(2);
    check("t1_stopped", {31'd0, Running}, 32'd0);
    check("t1_drained", expq.size(), 32'd0);

    // Step: short glitch rejected, long press gives one pulse
    do_reset("reset_t2");
    Step = 1'b0;
    tick(2);
    Step = 1'b1;
    tick(8);
    check("t2_glitch_count", {16'd0, CycleCount}, 32'd0);
    c = cyc;
    Step = 1'b0;
    push(c + 5, 16'd1);
    tick(10);
    Step = 1'b1;
    tick(8);
    check("t2_step_count", {16'd0, CycleCount}, 32'd1);
    check("t2_running", {31'd0, Running}, 32'd0);
    check("t2_drained", expq.size(), 32'd0);

    // Halt with Run dropping in the same cycle; HALTED is sticky
    do_reset("reset_t3");
    Run = 1'b1;
    tick(2);
    Halt = 1'b1;
    Run = 1'b0;
    tick(1);
    check("t3_halted", {31'd0, Halted}, 32'd1);
    check("t3_running", {31'd0, Running}, 32'd0);
    Halt = 1'b0;
    Run = 1'b1;
    tick(10);
    Run = 1'b0;
    Step = 1'b0;
    tick(10);
    Step = 1'b1;
    Run = 1'b1;
    tick(10);
    Run = 1'b0;
    check("t3_still_halted", {31'd0, Halted}, 32'd1);
    check("t3_still_stopped", {31'd0, Running}, 32'd0);
    check("t3_count", {16'd0, CycleCount}, 32'd0);

    // Breakpoint at PC=5
    do_reset("reset_t4");
    BpValid = 1'b1;
    BpAddr = 5'd5;
    PC = 5'd5;
    c = cyc;
    Run = 1'b1;
`ifndef BREAKPOINT_EN
    push(c + 5, 16'd1);
`endif
    tick(5);
`ifdef BREAKPOINT_EN
    check("t4_running", {31'd0, Running}, 32'd0);
    check("t4_bphit", {31'd0, BpHit}, 32'd1);
`else
    check("t4_running", {31'd0, Running}, 32'd1);
    check("t4_bphit", {31'd0, BpHit}, 32'd0);
`endif
    Run = 1'b0;
    tick(3);
`ifdef BREAKPOINT_EN
    check("t4_count", {16'd0, CycleCount}, 32'd0);
    check("t4_bphit_sticky", {31'd0, BpHit}, 32'd1);
`else
    check("t4_count", {16'd0, CycleCount}, 32'd1);
    check("t4_bphit_sticky", {31'd0, BpHit}, 32'd0);
`endif
    check("t4_drained", expq.size(), 32'd0);

    // Saturation from 0xFFFE
    do_reset("reset_t5");
    force dut.cycle_cnt = 16'hFFFE;
    tick(1);
    release dut.cycle_cnt;
    tick(1);
    check("t5_preload", {16'd0, CycleCount}, 32'h0000FFFE);
    c = cyc;
    Run = 1'b1;
    push(c + 5, 16'hFFFF);
    push(c + 9, 16'hFFFF);
    push(c + 13, 16'hFFFF);
    tick(13);
    Run = 1'b0;
    tick(2);
    check("t5_saturated", {16'd0, CycleCount}, 32'h0000FFFF);
    check("t5_drained", expq.size(), 32'd0);

    // Reset asserted one cycle before a tick cancels the pulse
    c = cyc;
    Run = 1'b1;
    tick(4);
    Reset = 1'b0;
    Run = 1'b0;
    #1;
    check_zero("t6_async");
    tick(1);
    check_zero("t6_held");
    Reset = 1'b1;
    tick(1);
    check("t6_release_cpuen", {31'd0, CpuEn}, 32'd0);
    tick(5);
    check_zero("t6_idle");

    check("final_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
